// File: rtl/tri_pkg.sv
// -----------------------------------------------------------------------------
// tri_pkg
// Constants and types shared by the triangle rendering engine and its
// downstream pixel-bitmap stage.
//   COORD_W_DEFAULT : default coordinate width (grid is 2^COORD_W square)
//   GRID_DEFAULT    : default grid side length in pixels
//   DUP_W_DEFAULT   : default width of the saturating duplicate counter
//   pixel_t         : packed {x, y} pixel coordinate at the default width
//   state_t         : readout controller state
// -----------------------------------------------------------------------------
package tri_pkg;

  localparam int COORD_W_DEFAULT = 3;
  localparam int GRID_DEFAULT    = 1 << COORD_W_DEFAULT;
  localparam int DUP_W_DEFAULT   = 8;

  typedef struct packed {
    logic [COORD_W_DEFAULT-1:0] x;
    logic [COORD_W_DEFAULT-1:0] y;
  } pixel_t;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

endpackage

// File: rtl/tri_bitmap_store.sv
// -----------------------------------------------------------------------------
// tri_bitmap_store
// 2^COORD_W x 2^COORD_W occupancy bitmap held in flops, one word per row.
// Ports:
//   clk, reset      : clock, synchronous active-high reset (clears bitmap)
//   set_en          : set bit (set_x, set_y) at this edge
//   set_x, set_y    : coordinate to set; don't-care when set_en=0
//   clr_all         : clear every bit at this edge (a same-edge set survives)
//   rd_idx          : row to read combinationally
//   rd_bits         : pre-edge contents of row rd_idx; bit i = column i
//   was_set         : pre-edge value of bit (set_x, set_y)
// -----------------------------------------------------------------------------
module tri_bitmap_store #(
  parameter int COORD_W = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      set_en,
  input  logic [COORD_W-1:0]        set_x,
  input  logic [COORD_W-1:0]        set_y,
  input  logic                      clr_all,
  input  logic [COORD_W-1:0]        rd_idx,
  output logic [(1<<COORD_W)-1:0]   rd_bits,
  output logic                      was_set
);

  localparam int GRID = 1 << COORD_W;

  logic [GRID-1:0] rows [GRID];

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: this array is reset on purpose: it is small flop storage and
      // the frame must read back empty after reset. A large RAM would not be.
      for (int r = 0; r < GRID; r++) rows[r] <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout; the later set deliberately
      // overrides the clear for its own bit, so a pixel arriving with clr stays.
      if (clr_all) begin
        for (int r = 0; r < GRID; r++) rows[r] <= '0;
      end
      if (set_en) rows[set_y][set_x] <= 1'b1;
    end
  end

  assign rd_bits = rows[rd_idx];
  assign was_set = rows[set_y][set_x];

endmodule

// File: rtl/tri_pixel_bitmap.sv
// -----------------------------------------------------------------------------
// tri_pixel_bitmap
// Accumulates the triangle engine's pixel stream into an occupancy bitmap,
// counts distinct pixels and duplicate hits, and reads the frame out one row
// per valid/ready transfer.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   po, xo, yo          : pixel valid and coordinate (accepted every cycle)
//   clr                 : clear bitmap and counters (honoured in IDLE only)
//   rd_req              : start a frame readout (honoured in IDLE, clr=0)
//   rd_valid, rd_ready  : row handshake
//   rd_row, rd_data     : row index and its bitmap (bit i = column i)
//   rd_last             : final row of the frame
//   pix_count           : distinct set pixels
//   dup_count           : writes to already-set pixels, saturating
//   busy                : readout in progress
// -----------------------------------------------------------------------------
module tri_pixel_bitmap
  import tri_pkg::*;
#(
  parameter int COORD_W = COORD_W_DEFAULT,
  parameter int DUP_W   = DUP_W_DEFAULT
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      po,
  input  logic [COORD_W-1:0]        xo,
  input  logic [COORD_W-1:0]        yo,
  input  logic                      clr,
  input  logic                      rd_req,
  output logic                      rd_valid,
  input  logic                      rd_ready,
  output logic [COORD_W-1:0]        rd_row,
  output logic [(1<<COORD_W)-1:0]   rd_data,
  output logic                      rd_last,
  output logic [2*COORD_W:0]        pix_count,
  output logic [DUP_W-1:0]          dup_count,
  output logic                      busy
);

  localparam int                 GRID     = 1 << COORD_W;
  localparam logic [COORD_W-1:0] LAST_ROW = '1;

  state_t             state;
  logic               clr_now;
  logic [COORD_W-1:0] next_row;
  logic [COORD_W-1:0] rd_idx;
  logic [GRID-1:0]    row_bits;
  logic               was_set;

  always_comb begin
    // NOTE: every signal gets a value before any branch, so no latch can form.
    clr_now  = 1'b0;
    next_row = rd_row + 1'b1;
    rd_idx   = '0;
    if (state == IDLE) clr_now = clr;
    // In SCAN the row port looks one row ahead so the next word is ready to
    // load on the transfer edge; in IDLE it presents row 0 for the start.
    if (state == SCAN) rd_idx = next_row;
  end

  tri_bitmap_store #(
    .COORD_W (COORD_W)
  ) u_store (
    .clk     (clk),
    .reset   (reset),
    .set_en  (po),
    .set_x   (xo),
    .set_y   (yo),
    .clr_all (clr_now),
    .rd_idx  (rd_idx),
    .rd_bits (row_bits),
    .was_set (was_set)
  );

  // Counters follow the same edge as the bitmap write; a pixel arriving with
  // clr lands in an empty bitmap, so it always counts as new.
  always_ff @(posedge clk) begin
    if (reset) begin
      pix_count <= '0;
      dup_count <= '0;
    end else if (clr_now) begin
      pix_count <= {{(2*COORD_W){1'b0}}, po};
      dup_count <= '0;
    end else if (po) begin
      if (was_set) begin
        if (dup_count != '1) dup_count <= dup_count + 1'b1;
      end else begin
        pix_count <= pix_count + 1'b1;
      end
    end
  end

  // Readout controller: rd_data is always captured from the pre-edge bitmap,
  // so a pixel shows up only in rows loaded after its write edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      rd_valid <= 1'b0;
      busy     <= 1'b0;
      rd_row   <= '0;
      rd_data  <= '0;
      rd_last  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (rd_req && !clr) begin
            state    <= SCAN;
            rd_valid <= 1'b1;
            busy     <= 1'b1;
            rd_row   <= '0;
            rd_data  <= row_bits;
            rd_last  <= (GRID == 1);
          end
        end
        SCAN: begin
          if (rd_valid && rd_ready) begin
            if (rd_last) begin
              state    <= IDLE;
              rd_valid <= 1'b0;
              busy     <= 1'b0;
              rd_row   <= '0;
              rd_data  <= '0;
              rd_last  <= 1'b0;
            end else begin
              rd_row   <= next_row;
              rd_data  <= row_bits;
              rd_last  <= (next_row == LAST_ROW);
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tri_pixel_bitmap.sv
// -----------------------------------------------------------------------------
// tb_tri_pixel_bitmap
// Self-checking bench for tri_pixel_bitmap: a hand-derived vector table for
// the basic frame, directed sequences for the multi-cycle corners, and a
// randomized run against a behavioural frame model.
// -----------------------------------------------------------------------------
module tb_tri_pixel_bitmap;

  localparam int CW = 3;
  localparam int G  = 1 << CW;
  localparam int DW = 8;
  localparam int DUP_MAX = (1 << DW) - 1;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            po = 1'b0;
  logic [CW-1:0]   xo = '0;
  logic [CW-1:0]   yo = '0;
  logic            clr = 1'b0;
  logic            rd_req = 1'b0;
  logic            rd_ready = 1'b0;
  logic            rd_valid;
  logic [CW-1:0]   rd_row;
  logic [G-1:0]    rd_data;
  logic            rd_last;
  logic [2*CW:0]   pix_count;
  logic [DW-1:0]   dup_count;
  logic            busy;

  always #5 clk = ~clk;

  tri_pixel_bitmap #(.COORD_W(CW), .DUP_W(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .po        (po),
    .xo        (xo),
    .yo        (yo),
    .clr       (clr),
    .rd_req    (rd_req),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_row    (rd_row),
    .rd_data   (rd_data),
    .rd_last   (rd_last),
    .pix_count (pix_count),
    .dup_count (dup_count),
    .busy      (busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural frame model: a 2-D bit grid, a duplicate tally, and the frame
  // position of the reader. Distinct count is derived by counting grid bits.
  // ---------------------------------------------------------------------------
  logic [G-1:0] m_bm [G];
  int           m_dup;
  bit           m_scan;
  int           m_row;
  logic [G-1:0] m_data;

  function automatic int m_pix();
    int n = 0;
    for (int r = 0; r < G; r++)
      for (int c = 0; c < G; c++)
        if (m_bm[r][c]) n++;
    return n;
  endfunction

  task automatic model_edge();
    logic [G-1:0] pre [G];
    bit was_scan;
    int px, py;
    pre      = m_bm;
    was_scan = m_scan;
    if (reset) begin
      for (int r = 0; r < G; r++) m_bm[r] = '0;
      m_dup = 0; m_scan = 0; m_row = 0; m_data = '0;
      return;
    end
    if (!was_scan) begin
      if (rd_req && !clr) begin
        m_scan = 1; m_row = 0; m_data = pre[0];
      end
    end else if (rd_ready) begin
      if (m_row == G - 1) begin
        m_scan = 0; m_row = 0; m_data = '0;
      end else begin
        m_row = m_row + 1; m_data = pre[m_row];
      end
    end
    if (!was_scan && clr) begin
      for (int r = 0; r < G; r++) m_bm[r] = '0;
      m_dup = 0;
    end
    if (po) begin
      px = int'(xo); py = int'(yo);
      if (m_bm[py][px]) begin
        if (m_dup < DUP_MAX) m_dup++;
      end else begin
        m_bm[py][px] = 1'b1;
      end
    end
  endtask

  task automatic check_model();
    check("m_valid", rd_valid, m_scan);
    check("m_busy",  busy,     m_scan);
    check("m_row",   rd_row,   m_row);
    check("m_last",  rd_last,  (m_scan && m_row == G - 1));
    check("m_pix",   pix_count, m_pix());
    check("m_dup",   dup_count, m_dup);
    if (m_scan) check("m_data", rd_data, m_data);
  endtask

  // Drive one cycle of inputs, let the edge happen, advance the model, and
  // leave time 1 unit past the edge for sampling.
  task automatic step(input bit p, input int x, input int y,
                      input bit c, input bit rq, input bit rdy);
    po = p; xo = CW'(x); yo = CW'(y);
    clr = c; rd_req = rq; rd_ready = rdy;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(0, 0, 0, 0, 0, 0);
    reset = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Vector table for the basic frame: inputs and hand-derived expectations.
  // ---------------------------------------------------------------------------
  typedef struct {
    bit         po;
    int         x;
    int         y;
    bit         clr;
    bit         rd_req;
    bit         rd_ready;
    bit         e_valid;
    int         e_row;
    logic [7:0] e_data;
    bit         e_last;
    int         e_pix;
    int         e_dup;
    bit         e_busy;
  } vec_t;

  vec_t vecs [12];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int q_row [$];
    logic [G-1:0] q_dat [$];
    bit pat [4];
    logic [G-1:0] exp_d;

    //              po x y clr rq rdy  val row data         last pix dup busy
    vecs[0]  = '{1, 1, 1, 0, 0, 0,  0, 0, 8'b00000000, 0, 1, 0, 0};
    vecs[1]  = '{1, 2, 1, 0, 0, 0,  0, 0, 8'b00000000, 0, 2, 0, 0};
    vecs[2]  = '{1, 1, 2, 0, 0, 0,  0, 0, 8'b00000000, 0, 3, 0, 0};
    vecs[3]  = '{0, 0, 0, 0, 1, 1,  1, 0, 8'b00000000, 0, 3, 0, 1};
    vecs[4]  = '{0, 0, 0, 0, 0, 1,  1, 1, 8'b00000110, 0, 3, 0, 1};
    vecs[5]  = '{0, 0, 0, 0, 0, 1,  1, 2, 8'b00000010, 0, 3, 0, 1};
    vecs[6]  = '{0, 0, 0, 0, 0, 1,  1, 3, 8'b00000000, 0, 3, 0, 1};
    vecs[7]  = '{0, 0, 0, 0, 0, 1,  1, 4, 8'b00000000, 0, 3, 0, 1};
    vecs[8]  = '{0, 0, 0, 0, 0, 1,  1, 5, 8'b00000000, 0, 3, 0, 1};
    vecs[9]  = '{0, 0, 0, 0, 0, 1,  1, 6, 8'b00000000, 0, 3, 0, 1};
    vecs[10] = '{0, 0, 0, 0, 0, 1,  1, 7, 8'b00000000, 1, 3, 0, 1};
    vecs[11] = '{0, 0, 0, 0, 0, 1,  0, 0, 8'b00000000, 0, 3, 0, 0};

    // ---- reset state -------------------------------------------------------
    do_reset();
    check("rst_valid", rd_valid, 0);
    check("rst_busy",  busy,     0);
    check("rst_row",   rd_row,   0);
    check("rst_data",  rd_data,  0);
    check("rst_last",  rd_last,  0);
    check("rst_pix",   pix_count, 0);
    check("rst_dup",   dup_count, 0);

    // ---- 1: basic frame from the vector table ------------------------------
    for (int i = 0; i < 12; i++) begin
      step(vecs[i].po, vecs[i].x, vecs[i].y, vecs[i].clr, vecs[i].rd_req, vecs[i].rd_ready);
      check($sformatf("t1_valid[%0d]", i), rd_valid,  vecs[i].e_valid);
      check($sformatf("t1_busy[%0d]",  i), busy,      vecs[i].e_busy);
      check($sformatf("t1_row[%0d]",   i), rd_row,    vecs[i].e_row);
      check($sformatf("t1_last[%0d]",  i), rd_last,   vecs[i].e_last);
      check($sformatf("t1_pix[%0d]",   i), pix_count, vecs[i].e_pix);
      check($sformatf("t1_dup[%0d]",   i), dup_count, vecs[i].e_dup);
      if (vecs[i].e_valid) check($sformatf("t1_data[%0d]", i), rd_data, vecs[i].e_data);
    end

    // ---- 2: duplicate saturation -------------------------------------------
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 3, 4, 0, 0, 0);
    check("t2_pix_a", pix_count, 1);
    check("t2_dup_a", dup_count, 2);
    for (int i = 0; i < 300; i++) step(1, 0, 0, 0, 0, 0);
    check("t2_pix", pix_count, 2);
    check("t2_dup", dup_count, 255);
    check_model();

    // ---- 3: stalled readout, ready pattern 1,0,0,1 -------------------------
    do_reset();
    for (int i = 0; i < G; i++) step(1, i, i, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    check_model();
    pat = '{1, 0, 0, 1};
    for (int k = 0; k < 64 && busy; k++) begin
      if (rd_valid && pat[k % 4]) begin
        q_row.push_back(int'(rd_row));
        q_dat.push_back(rd_data);
      end
      step(0, 0, 0, 0, 0, pat[k % 4]);
      check_model();
    end
    check("t3_busy_end", busy, 0);
    check("t3_ntransfers", q_row.size(), G);
    for (int i = 0; i < q_row.size() && i < G; i++) begin
      exp_d = G'(1 << i);
      check($sformatf("t3_row[%0d]", i), q_row[i], i);
      check($sformatf("t3_data[%0d]", i), q_dat[i], exp_d);
    end

    // ---- 4: clr with a same-cycle pixel; clr with rd_req -------------------
    do_reset();
    for (int i = 0; i < 10; i++) step(1, i % G, (i * 3) % G, 0, 0, 0);
    check_model();
    step(1, 5, 5, 1, 0, 0);
    check("t4_pix", pix_count, 1);
    check("t4_dup", dup_count, 0);
    step(0, 0, 0, 0, 1, 1);
    for (int r = 0; r < G; r++) begin
      check($sformatf("t4_row[%0d]", r), rd_row, r);
      check($sformatf("t4_data[%0d]", r), rd_data, (r == 5) ? 32'h20 : 32'h0);
      step(0, 0, 0, 0, 0, 1);
    end
    check("t4_done_busy", busy, 0);
    step(0, 0, 0, 1, 1, 1);
    check("t4_clrreq_busy",  busy,     0);
    check("t4_clrreq_valid", rd_valid, 0);
    step(0, 0, 0, 0, 0, 1);
    check("t4_dropped_busy", busy, 0);
    check_model();

    // ---- 5: writes during SCAN; clr/rd_req ignored mid-frame ---------------
    do_reset();
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 1);
    check("t5_row1_idx",  rd_row,  1);
    check("t5_row1_data", rd_data, 0);
    step(0, 0, 0, 0, 0, 1);
    check("t5_row2_idx", rd_row, 2);
    step(1, 0, 1, 0, 0, 1);
    step(1, 0, 6, 1, 1, 0);
    check("t5_pix_mid",  pix_count, 2);
    check("t5_row_hold", rd_row,    3);
    check_model();
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 0, 1);
      check_model();
    end
    check("t5_row6_idx",  rd_row,  6);
    check("t5_row6_data", rd_data, 1);
    step(0, 0, 0, 0, 0, 1);
    check("t5_row7_last", rd_last, 1);
    step(0, 0, 0, 0, 0, 1);
    check("t5_end_busy", busy, 0);
    check("t5_end_pix",  pix_count, 2);
    step(0, 0, 0, 0, 0, 1);
    check("t5_no_defer_busy", busy, 0);
    check("t5_no_defer_pix",  pix_count, 2);

    // ---- 6: reset mid-SCAN -------------------------------------------------
    do_reset();
    for (int i = 0; i < 6; i++) step(1, i, 7 - i, 0, 0, 0);
    step(0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 1);
    check("t6_row4", rd_row, 4);
    reset = 1'b1;
    step(0, 0, 0, 0, 0, 1);
    reset = 1'b0;
    check("t6_valid", rd_valid, 0);
    check("t6_busy",  busy,     0);
    check("t6_row",   rd_row,   0);
    check("t6_pix",   pix_count, 0);
    check("t6_dup",   dup_count, 0);
    step(0, 0, 0, 0, 1, 1);
    for (int r = 0; r < G; r++) begin
      check($sformatf("t6_zero_row[%0d]", r), rd_row, r);
      check($sformatf("t6_zero_data[%0d]", r), rd_data, 0);
      step(0, 0, 0, 0, 0, 1);
    end
    check("t6_end_busy", busy, 0);

    // ---- randomized run against the model ----------------------------------
    do_reset();
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 99) < 60, $urandom_range(0, G - 1), $urandom_range(0, G - 1),
           $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 10,
           $urandom_range(0, 99) < 60);
      check_model();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
